fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_mem_if.sv | 15 +
 rtl/icache_array.sv | 46 ++++
 rtl/fetch_stage.sv | 92 +++++++++
 tb/tb_fetch_stage.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types, constants and address-field width helpers for the fetch stage.
// Pure declarations: no logic, no latency, no flow control.
package fetch_pkg;

    localparam int WORD_W = 32;

    typedef logic [0:0] state_t;
    localparam state_t ST_RUN    = 1'b0;
    localparam state_t ST_REFILL = 1'b1;

    function automatic int offset_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int num_lines, input int line_words);
        return WORD_W - 2 - $clog2(line_words) - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/fetch_mem_if.sv
// Line refill bus between the fetch stage and the backing memory.
// Request is level-held until a single-cycle ack carries the whole line.
interface fetch_mem_if
    import fetch_pkg::*;
#(
    parameter int LINE_WORDS = 4
) ();
    logic                         mem_req;
    logic [WORD_W-1:0]            mem_addr;
    logic                         mem_ack;
    logic [LINE_WORDS*WORD_W-1:0] mem_line;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_line);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_line);
endinterface

// File: rtl/icache_array.sv
// Direct-mapped tag/valid/data store: combinational read, one write port.
// Read latency 0; write visible the cycle after wr_en; never backpressures.
module icache_array
    import fetch_pkg::*;
#(
    parameter int NUM_LINES  = 8,
    parameter int LINE_WORDS = 4,
    parameter int OFF_W      = offset_w(LINE_WORDS),
    parameter int IDX_W      = index_w(NUM_LINES),
    parameter int TAG_W      = tag_w(NUM_LINES, LINE_WORDS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [IDX_W-1:0]             rd_index,
    input  logic [TAG_W-1:0]             rd_tag,
    input  logic [OFF_W-1:0]             rd_offset,
    output logic                         hit,
    output logic [WORD_W-1:0]            rd_word,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_index,
    input  logic [TAG_W-1:0]             wr_tag,
    input  logic [LINE_WORDS*WORD_W-1:0] wr_line
);
    logic [NUM_LINES-1:0]                   valid_q;
    logic [TAG_W-1:0]                       tag_q  [NUM_LINES];
    logic [LINE_WORDS-1:0][WORD_W-1:0]      data_q [NUM_LINES];

    // Only the valid bits are reset; tag and data are don't-care until valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_line;
        end
    end

    assign hit     = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
    assign rd_word = data_q[rd_index][rd_offset];
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, direct-mapped I-cache lookup, line refill FSM.
// Hit delivers the word in the same cycle; stall holds PC on hit, redirects always win.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int          NUM_LINES  = 8,
    parameter int          LINE_WORDS = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WORD_W-1:0]  branch_target,
    input  logic               pc_src,
    input  logic               stall,
    output logic [WORD_W-1:0]  instruction,
    output logic [WORD_W-1:0]  next_pc,
    output logic               valid,
    fetch_mem_if.master        mem
);
    localparam int OFF_W    = offset_w(LINE_WORDS);
    localparam int IDX_W    = index_w(NUM_LINES);
    localparam int TAG_W    = tag_w(NUM_LINES, LINE_WORDS);
    localparam int LINE_LSB = OFF_W + 2;
    localparam logic [WORD_W-1:0] LINE_MASK = (32'd1 << LINE_LSB) - 32'd1;

    state_t            state_q;
    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] refill_addr_q;
    logic [WORD_W-1:0] pending_target_q;
    logic              pending_q;
    logic              hit;
    logic [WORD_W-1:0] rd_word;

    icache_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_icache_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_index  (pc_q[LINE_LSB +: IDX_W]),
        .rd_tag    (pc_q[WORD_W-1 -: TAG_W]),
        .rd_offset (pc_q[2 +: OFF_W]),
        .hit       (hit),
        .rd_word   (rd_word),
        .wr_en     ((state_q == ST_REFILL) && mem.mem_ack),
        .wr_index  (refill_addr_q[LINE_LSB +: IDX_W]),
        .wr_tag    (refill_addr_q[WORD_W-1 -: TAG_W]),
        .wr_line   (mem.mem_line)
    );

    assign next_pc      = pc_q + 32'd4;
    assign valid        = (state_q == ST_RUN) && hit;
    assign instruction  = hit ? rd_word : '0;
    assign mem.mem_req  = (state_q == ST_REFILL);
    assign mem.mem_addr = refill_addr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= ST_RUN;
            pc_q             <= RESET_PC;
            refill_addr_q    <= '0;
            pending_q        <= 1'b0;
            pending_target_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hit) begin
                        if (pc_src)      pc_q <= branch_target;
                        else if (!stall) pc_q <= next_pc;
                    end else begin
                        // A redirect on a miss still refills the line that missed.
                        state_q       <= ST_REFILL;
                        refill_addr_q <= pc_q & ~LINE_MASK;
                        if (pc_src) pc_q <= branch_target;
                    end
                end
                ST_REFILL: begin
                    if (mem.mem_ack) begin
                        state_q   <= ST_RUN;
                        pending_q <= 1'b0;
                        if (pc_src)         pc_q <= branch_target;
                        else if (pending_q) pc_q <= pending_target_q;
                    end else if (pc_src) begin
                        pending_q        <= 1'b1;
                        pending_target_q <= branch_target;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: refill timing, stall, redirects, aliasing, wrap, reset.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] branch_target;
    logic        pc_src;
    logic        stall;
    logic [31:0] instruction;
    logic [31:0] next_pc;
    logic        valid;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_mem_if #(.LINE_WORDS(4)) mem_bus ();

    fetch_stage #(
        .NUM_LINES  (8),
        .LINE_WORDS (4),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .branch_target (branch_target),
        .pc_src        (pc_src),
        .stall         (stall),
        .instruction   (instruction),
        .next_pc       (next_pc),
        .valid         (valid),
        .mem           (mem_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] ins,
                              input logic [31:0] npc);
        check({tag, ".valid"}, {31'd0, valid}, {31'd0, v});
        check({tag, ".instr"}, instruction, ins);
        check({tag, ".next_pc"}, next_pc, npc);
    endtask

    // Memory image: each word holds 0x11 plus its word address.
    function automatic logic [127:0] line_for(input logic [31:0] a);
        logic [31:0]  base;
        logic [127:0] l;
        base = a & ~32'hF;
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = 32'h11 + (base >> 2) + w;
        return l;
    endfunction

    task automatic wait_refill(input string tag, input logic [31:0] addr, input int n);
        check({tag, ".req"}, {31'd0, mem_bus.mem_req}, 32'd1);
        check({tag, ".addr"}, mem_bus.mem_addr, addr);
        check({tag, ".valid"}, {31'd0, valid}, 32'd0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, ".req_held"}, {31'd0, mem_bus.mem_req}, 32'd1);
        end
    endtask

    task automatic ack_line(input logic [31:0] addr);
        mem_bus.mem_ack  = 1'b1;
        mem_bus.mem_line = line_for(addr);
        @(negedge clk);
        mem_bus.mem_ack  = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        pc_src        = 1'b1;
        branch_target = tgt;
        @(negedge clk);
        pc_src        = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; pc_src = 1'b0; stall = 1'b0; branch_target = '0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_line = '0;
        repeat (2) @(negedge clk);
        expect_out("reset", 1'b0, 32'h0, 32'h4);
        check("reset.req", {31'd0, mem_bus.mem_req}, 32'd0);
        rst_n = 1'b1;

        // Cold miss at 0, ack three cycles after the request.
        @(negedge clk);
        wait_refill("fill0", 32'h0, 3);
        ack_line(32'h0);
        expect_out("pc0", 1'b1, 32'h11, 32'h4);
        @(negedge clk);
        expect_out("pc4", 1'b1, 32'h12, 32'h8);

        stall = 1'b1;
        @(negedge clk);
        expect_out("stall1", 1'b1, 32'h12, 32'h8);
        @(negedge clk);
        expect_out("stall2", 1'b1, 32'h12, 32'h8);
        stall = 1'b0;
        @(negedge clk);
        expect_out("pc8", 1'b1, 32'h13, 32'hC);
        @(negedge clk);
        expect_out("pcC", 1'b1, 32'h14, 32'h10);
        @(negedge clk);
        expect_out("miss10", 1'b0, 32'h0, 32'h14);

        // Redirect to 0x40 while 0x10 refill is outstanding.
        @(negedge clk);
        wait_refill("fill10", 32'h10, 1);
        redirect(32'h40);
        check("fill10.req_after_redir", {31'd0, mem_bus.mem_req}, 32'd1);
        check("fill10.addr_after_redir", mem_bus.mem_addr, 32'h10);
        check("fill10.pc_held", next_pc, 32'h14);
        ack_line(32'h10);
        expect_out("pc40", 1'b0, 32'h0, 32'h44);

        // Two redirects during one refill: the later (0x10, resident) wins.
        @(negedge clk);
        wait_refill("fill40", 32'h40, 2);
        redirect(32'h80);
        redirect(32'h10);
        ack_line(32'h40);
        expect_out("last_wins", 1'b1, 32'h15, 32'h14);

        // Redirect coinciding with ack, to a resident word.
        redirect(32'h20);
        expect_out("miss20", 1'b0, 32'h0, 32'h24);
        @(negedge clk);
        wait_refill("fill20", 32'h20, 1);
        pc_src = 1'b1; branch_target = 32'h8;
        ack_line(32'h20);
        pc_src = 1'b0;
        expect_out("ack_redir", 1'b1, 32'h13, 32'hC);

        // 0x80 aliases index 0 and evicts line 0.
        redirect(32'h80);
        expect_out("miss80", 1'b0, 32'h0, 32'h84);
        @(negedge clk);
        wait_refill("fill80", 32'h80, 1);
        ack_line(32'h80);
        expect_out("pc80", 1'b1, 32'h31, 32'h84);
        redirect(32'h0);
        expect_out("evicted0", 1'b0, 32'h0, 32'h4);
        @(negedge clk);
        wait_refill("refill0", 32'h0, 1);
        ack_line(32'h0);
        expect_out("pc0_again", 1'b1, 32'h11, 32'h4);

        // PC wrap at the top of the address space.
        redirect(32'hFFFF_FFFC);
        expect_out("missTop", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        wait_refill("fillTop", 32'hFFFF_FFF0, 1);
        ack_line(32'hFFFF_FFF0);
        expect_out("pcTop", 1'b1, 32'h4000_0010, 32'h0);
        @(negedge clk);
        expect_out("wrap0", 1'b1, 32'h11, 32'h4);

        // Reset in the middle of a refill, followed by a stale ack.
        redirect(32'h30);
        expect_out("miss30", 1'b0, 32'h0, 32'h34);
        @(negedge clk);
        wait_refill("fill30", 32'h30, 1);
        rst_n = 1'b0;
        @(negedge clk);
        expect_out("rst_mid", 1'b0, 32'h0, 32'h4);
        check("rst_mid.req", {31'd0, mem_bus.mem_req}, 32'd0);
        rst_n = 1'b1;
        ack_line(32'h30);
        check("stale.req", {31'd0, mem_bus.mem_req}, 32'd1);
        check("stale.addr", mem_bus.mem_addr, 32'h0);
        check("stale.valid", {31'd0, valid}, 32'd0);
        @(negedge clk);
        check("stale.req_held", {31'd0, mem_bus.mem_req}, 32'd1);
        ack_line(32'h0);
        expect_out("post_rst", 1'b1, 32'h11, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
